// File: rtl/invader_pkg.sv
// Shared invader-game types and the step-period rule used by the march and shot schedulers.
// Pure declarations and functions; no clocked logic.
// No flow control.
package invader_pkg;

    localparam int SPEED_LEVEL_W = 3;
    localparam int FRAME_CNT_W   = 6;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START_WAIT = 3'd1,
        ST_MARCH      = 3'd2,
        ST_DESCEND    = 3'd3,
        ST_FROZEN     = 3'd4,
        ST_LANDED     = 3'd5,
        ST_CLEARED    = 3'd6
    } march_st_t;

    // Signed 7-bit so a large level*step goes negative and is caught by the floor.
    function automatic logic [FRAME_CNT_W-1:0] calc_period(
        input logic [SPEED_LEVEL_W-1:0] lvl,
        input int                       base,
        input int                       step,
        input int                       min_p
    );
        logic signed [6:0] p;
        logic signed [6:0] floor_p;
        p       = 7'(base) - 7'(step * int'(lvl));
        floor_p = 7'(min_p);
        if (p < floor_p) begin
            p = floor_p;
        end
        return FRAME_CNT_W'(p);
    endfunction

endpackage

// File: rtl/march_period_timer.sv
// Frame counter with a >= compare against the live period; pulses step_evt on the qualifying startOfFrame.
// Combinational step_evt in the same cycle as startOfFrame; counter clears on the event.
// No flow control; clr has priority, en gates counting.
module march_period_timer
    import invader_pkg::*;
(
    input  logic                   clk,
    input  logic                   resetN,
    input  logic                   clr,
    input  logic                   en,
    input  logic                   startOfFrame,
    input  logic [FRAME_CNT_W-1:0] period,
    output logic                   step_evt
);

    logic [FRAME_CNT_W-1:0] frame_cnt;

    // >= rather than == so a period that shrinks below the count fires on the next frame.
    assign step_evt = en && startOfFrame &&
                      ((FRAME_CNT_W+1)'(frame_cnt) + (FRAME_CNT_W+1)'(1) >= (FRAME_CNT_W+1)'(period));

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            frame_cnt <= '0;
        end else if (clr) begin
            frame_cnt <= '0;
        end else if (en && startOfFrame) begin
            frame_cnt <= step_evt ? '0 : frame_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/invader_march_ctrl.sv
// Invader fleet march sequencer: step/descend pulses, direction reversal, kill-driven speed-up (MARCH_CTRL_SPEEDUP_EN).
// Pulses and status are registered, one clk after the deciding startOfFrame/invaderHit.
// No flow control; gameStart overrides every other event in its cycle.
module invader_march_ctrl
    import invader_pkg::*;
#(
    parameter int BASE_PERIOD     = 30,
    parameter int PERIOD_STEP     = 4,
    parameter int MIN_PERIOD      = 2,
    parameter int KILLS_PER_LEVEL = 4,
    parameter int INVADER_COUNT   = 32,
    parameter int START_FRAMES    = 30,
    parameter int LAND_Y          = 400
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     startOfFrame,
    input  logic                     gameStart,
    input  logic                     invaderHit,
    input  logic                     edgeHit,
    input  logic                     freeze,
    input  logic [10:0]              fleetBottomY,
    output logic                     stepPulse,
    output logic                     descendPulse,
    output logic                     dirRight,
    output logic [SPEED_LEVEL_W-1:0] speedLevel,
    output logic                     landed,
    output logic                     waveCleared
);

    localparam int KILL_W = $clog2(INVADER_COUNT + 1);

    march_st_t                state;
    logic [KILL_W-1:0]        kill_cnt;
    logic [KILL_W-1:0]        kill_nxt;
    logic                     edge_latch;
    logic [FRAME_CNT_W-1:0]   period;
    logic [FRAME_CNT_W-1:0]   timer_period;
    logic [SPEED_LEVEL_W-1:0] level_nxt;
    logic                     counting;
    logic                     kill_ok;
    logic                     clear_now;
    logic                     timer_clr;
    logic                     step_evt;

    function automatic logic [SPEED_LEVEL_W-1:0] level_of(input logic [KILL_W-1:0] k);
        int l;
        l = int'(k) / KILLS_PER_LEVEL;
        if (l > 7) begin
            l = 7;
        end
        return SPEED_LEVEL_W'(l);
    endfunction

`ifdef MARCH_CTRL_SPEEDUP_EN
    assign level_nxt = level_of(kill_nxt);
    assign period    = calc_period(speedLevel, BASE_PERIOD, PERIOD_STEP, MIN_PERIOD);
`else
    assign level_nxt = '0;
    assign period    = calc_period('0, BASE_PERIOD, PERIOD_STEP, MIN_PERIOD);
`endif

    assign counting     = (state == ST_START_WAIT) || (state == ST_MARCH) || (state == ST_DESCEND);
    assign kill_nxt     = kill_cnt + 1'b1;
    assign kill_ok      = invaderHit && (counting || state == ST_FROZEN) &&
                          (kill_cnt != KILL_W'(INVADER_COUNT));
    assign clear_now    = kill_ok && (kill_nxt == KILL_W'(INVADER_COUNT));
    assign timer_period = (state == ST_START_WAIT) ? FRAME_CNT_W'(START_FRAMES) : period;
    assign timer_clr    = gameStart || (state == ST_FROZEN);

    march_period_timer u_timer (
        .clk          (clk),
        .resetN       (resetN),
        .clr          (timer_clr),
        .en           (counting),
        .startOfFrame (startOfFrame),
        .period       (timer_period),
        .step_evt     (step_evt)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= ST_IDLE;
            kill_cnt     <= '0;
            edge_latch   <= 1'b0;
            stepPulse    <= 1'b0;
            descendPulse <= 1'b0;
            dirRight     <= 1'b1;
            speedLevel   <= '0;
            landed       <= 1'b0;
            waveCleared  <= 1'b0;
        end else begin
            stepPulse    <= 1'b0;
            descendPulse <= 1'b0;
            if (gameStart) begin
                state       <= ST_START_WAIT;
                kill_cnt    <= '0;
                edge_latch  <= 1'b0;
                dirRight    <= 1'b1;
                speedLevel  <= '0;
                landed      <= 1'b0;
                waveCleared <= 1'b0;
            end else begin
                if (kill_ok) begin
                    kill_cnt   <= kill_nxt;
                    speedLevel <= level_nxt;
                end
                if (clear_now) begin
                    state       <= ST_CLEARED;
                    waveCleared <= 1'b1;
                end else begin
                    case (state)
                        ST_START_WAIT: if (step_evt) state <= ST_MARCH;
                        ST_MARCH: begin
                            if (edgeHit) edge_latch <= 1'b1;
                            if (freeze) begin
                                state <= ST_FROZEN;
                            end else if (step_evt) begin
                                // A latched edge turns this step into a reversal plus descend.
                                if (edge_latch) begin
                                    dirRight     <= ~dirRight;
                                    descendPulse <= 1'b1;
                                    edge_latch   <= 1'b0;
                                    state        <= ST_DESCEND;
                                end else begin
                                    stepPulse <= 1'b1;
                                end
                            end
                        end
                        ST_DESCEND: begin
                            if (freeze) begin
                                state <= ST_FROZEN;
                            end else if (step_evt) begin
                                if (fleetBottomY >= 11'(LAND_Y)) begin
                                    state  <= ST_LANDED;
                                    landed <= 1'b1;
                                end else begin
                                    state <= ST_MARCH;
                                end
                            end
                        end
                        ST_FROZEN: if (!freeze) state <= ST_MARCH;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_invader_march_ctrl.sv
// Randomized bench for invader_march_ctrl: a frame-level reference model queues the expected
// registered outputs for every clock; an independent monitor pops and compares after each edge.
module tb_invader_march_ctrl;

    localparam int BASE_PERIOD     = 30;
    localparam int PERIOD_STEP     = 4;
    localparam int MIN_PERIOD      = 2;
    localparam int KILLS_PER_LEVEL = 4;
    localparam int INVADER_COUNT   = 32;
    localparam int START_FRAMES    = 30;
    localparam int LAND_Y          = 400;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic        gameStart = 1'b0;
    logic        invaderHit = 1'b0;
    logic        edgeHit = 1'b0;
    logic        freeze = 1'b0;
    logic [10:0] fleetBottomY = 11'd100;
    logic        stepPulse;
    logic        descendPulse;
    logic        dirRight;
    logic [2:0]  speedLevel;
    logic        landed;
    logic        waveCleared;

    invader_march_ctrl #(
        .BASE_PERIOD     (BASE_PERIOD),
        .PERIOD_STEP     (PERIOD_STEP),
        .MIN_PERIOD      (MIN_PERIOD),
        .KILLS_PER_LEVEL (KILLS_PER_LEVEL),
        .INVADER_COUNT   (INVADER_COUNT),
        .START_FRAMES    (START_FRAMES),
        .LAND_Y          (LAND_Y)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .gameStart    (gameStart),
        .invaderHit   (invaderHit),
        .edgeHit      (edgeHit),
        .freeze       (freeze),
        .fleetBottomY (fleetBottomY),
        .stepPulse    (stepPulse),
        .descendPulse (descendPulse),
        .dirRight     (dirRight),
        .speedLevel   (speedLevel),
        .landed       (landed),
        .waveCleared  (waveCleared)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic       ds;
        logic       dr;
        logic [2:0] lv;
        logic       ld;
        logic       wc;
    } exp_t;

    typedef enum {M_IDLE, M_WAIT, M_MARCH, M_DESC, M_FROZEN, M_LANDED, M_CLEARED} mmode_t;

    exp_t   q[$];
    int     total = 0;
    int     bad = 0;
    int     n_step = 0;
    int     n_desc = 0;

    // Reference model: frames elapsed since the last step event, kills, pending edge, sticky flags.
    mmode_t m_mode;
    int     m_elapsed;
    int     m_kills;
    bit     m_edge;
    bit     m_dir;
    bit     m_land;
    bit     m_clr;
    bit     m_step;
    bit     m_desc;

    function automatic int exp_level(input int k);
`ifdef MARCH_CTRL_SPEEDUP_EN
        return (k / KILLS_PER_LEVEL > 7) ? 7 : k / KILLS_PER_LEVEL;
`else
        return 0;
`endif
    endfunction

    function automatic int exp_period(input int k);
        int p;
        p = BASE_PERIOD - exp_level(k) * PERIOD_STEP;
        return (p < MIN_PERIOD) ? MIN_PERIOD : p;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_elapsed = 0; m_kills = 0; m_edge = 0;
        m_dir = 1; m_land = 0; m_clr = 0; m_step = 0; m_desc = 0;
    endtask

    task automatic model_step(input logic s, input logic g, input logic h, input logic e,
                              input logic f, input logic [10:0] y);
        bit fire;
        int need;
        fire = 0; m_step = 0; m_desc = 0;
        if (g) begin
            m_mode = M_WAIT; m_elapsed = 0; m_kills = 0; m_edge = 0;
            m_land = 0; m_clr = 0; m_dir = 1;
            return;
        end
        if (s && m_mode inside {M_WAIT, M_MARCH, M_DESC}) begin
            need = (m_mode == M_WAIT) ? START_FRAMES : exp_period(m_kills);
            if (m_elapsed + 1 >= need) begin
                fire = 1; m_elapsed = 0;
            end else begin
                m_elapsed++;
            end
        end
        if (h && m_mode inside {M_WAIT, M_MARCH, M_DESC, M_FROZEN} && m_kills < INVADER_COUNT) begin
            m_kills++;
            if (m_kills == INVADER_COUNT) begin
                m_mode = M_CLEARED; m_clr = 1;
                return;
            end
        end
        case (m_mode)
            M_WAIT: if (fire) m_mode = M_MARCH;
            M_MARCH: begin
                if (f) begin
                    m_edge |= e; m_mode = M_FROZEN; m_elapsed = 0;
                end else if (fire && m_edge) begin
                    m_dir = !m_dir; m_desc = 1; m_edge = 0; m_mode = M_DESC;
                end else begin
                    m_step = fire; m_edge |= e;
                end
            end
            M_DESC: begin
                if (f) begin
                    m_mode = M_FROZEN; m_elapsed = 0;
                end else if (fire) begin
                    if (y >= LAND_Y) begin
                        m_mode = M_LANDED; m_land = 1;
                    end else begin
                        m_mode = M_MARCH;
                    end
                end
            end
            M_FROZEN: if (!f) begin m_mode = M_MARCH; m_elapsed = 0; end
            default: ;
        endcase
    endtask

    function automatic exp_t cur_out();
        exp_t r;
        r.st = m_step; r.ds = m_desc; r.dr = m_dir;
        r.lv = 3'(exp_level(m_kills)); r.ld = m_land; r.wc = m_clr;
        return r;
    endfunction

    // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
    task automatic cyc(input logic s, input logic h, input logic e, input logic f,
                       input logic g, input logic [10:0] y);
        @(negedge clk);
        startOfFrame = s; invaderHit = h; edgeHit = e; freeze = f; gameStart = g; fleetBottomY = y;
        if (!resetN) model_reset();
        else model_step(s, g, h, e, f, y);
        q.push_back(cur_out());
    endtask

    function automatic logic rnd(input int pct);
        return 1'($urandom_range(99) < pct);
    endfunction

    task automatic frames(input int n, input int hit_pct, input int edge_pct,
                          input logic f, input logic [10:0] y);
        for (int i = 0; i < n; i++) begin
            int   gap;
            logic e;
            gap = $urandom_range(1, 3);
            e = rnd(edge_pct);
            for (int j = 0; j < gap; j++) cyc(1'b0, rnd(hit_pct), e, f, 1'b0, y);
            cyc(1'b1, rnd(hit_pct), e, f, 1'b0, y);
        end
    endtask

    task automatic start_game(input logic [10:0] y);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, y);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if (stepPulse) n_step++;
                if (descendPulse) n_desc++;
                if (stepPulse !== e.st || descendPulse !== e.ds || dirRight !== e.dr ||
                    speedLevel !== e.lv || landed !== e.ld || waveCleared !== e.wc) begin
                    bad++;
                    $display("FAIL outputs t=%0t got step=%b desc=%b dir=%b lvl=%0d land=%b clr=%b want step=%b desc=%b dir=%b lvl=%0d land=%b clr=%b",
                             $time, stepPulse, descendPulse, dirRight, speedLevel, landed, waveCleared,
                             e.st, e.ds, e.dr, e.lv, e.ld, e.wc);
                end
            end
        end
    end

    initial begin : stimulus
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd100);
        resetN = 1'b1;

        // Start wait then plain marching.
        start_game(11'd100);
        frames(START_FRAMES, 0, 0, 1'b0, 11'd100);
        frames(65, 0, 0, 1'b0, 11'd100);

        // One-frame edge hit mid-period, then descend and resume.
        frames(10, 0, 0, 1'b0, 11'd100);
        frames(1, 0, 100, 1'b0, 11'd100);
        frames(80, 0, 0, 1'b0, 11'd100);

        // Eight kills, some on frame boundaries, then the remainder to clear the wave.
        for (int i = 0; i < 8; i++) begin
            cyc(1'($urandom_range(1)), 1'b1, 1'b0, 1'b0, 1'b0, 11'd100);
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd100);
        end
        frames(70, 0, 0, 1'b0, 11'd100);
        for (int i = 0; i < 24; i++) begin
            cyc(1'($urandom_range(1)), 1'b1, 1'b0, 1'b0, 1'b0, 11'd100);
            frames(1, 0, 0, 1'b0, 11'd100);
        end
        frames(40, 0, 0, 1'b0, 11'd100);

        // Landing on the descend that follows an edge.
        start_game(11'd100);
        frames(START_FRAMES + 10, 0, 0, 1'b0, 11'd100);
        frames(1, 0, 100, 1'b0, 11'd100);
        frames(70, 0, 0, 1'b0, 11'd405);
        frames(5, 0, 0, 1'b0, 11'd405);
        start_game(11'd100);

        // Freeze during march, then release.
        frames(START_FRAMES + 12, 0, 0, 1'b0, 11'd100);
        frames(10, 0, 0, 1'b1, 11'd100);
        frames(40, 0, 0, 1'b0, 11'd100);

        // Random mix of everything.
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(14) == 0) start_game(11'($urandom_range(380, 420)));
            frames($urandom_range(1, 20), $urandom_range(0, 5), $urandom_range(0, 30),
                   1'($urandom_range(7) == 0), 11'($urandom_range(380, 420)));
        end

        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd100);
        @(posedge clk);
        #5;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want 0", q.size());
        end
        total++;
        if (n_step == 0 || n_desc == 0) begin
            bad++;
            $display("FAIL activity steps=%0d descends=%0d want both nonzero", n_step, n_desc);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
